izh_neuron_array: RTL and testbench
===================================

IZH_NEURON_ARRAY -- requirements
Module: izh_neuron_array

Interface
REQ-001 Parameter N_NEUR, default 4, number of time-multiplexed neurons (2..16).
REQ-002 Parameter W, default 18, state word width, signed two's complement.
REQ-003 Parameter F, default 16, fraction bits of the state format (F <= W-2).
REQ-004 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port rst_n  in  1  reset, synchronous and active-low.
REQ-006 Port ena  in  1  global enable; low freezes every register except reset.
REQ-007 Port step  in  1  one-cycle request to start a sweep over all neurons.
REQ-008 Port cfg_wr  in  1  config write strobe.
REQ-009 Port cfg_addr  in  4  target neuron index.
REQ-010 Port cfg_sel  in  1  0 = mode register (cfg_data[2:0]), 1 = input current (cfg_data[7:0], signed).
REQ-011 Port cfg_data  in  8  config write data.
REQ-012 Port mon_sel  in  4  neuron whose membrane voltage drives v_mon.
REQ-013 Port busy  out  1  high while a sweep is in progress.
REQ-014 Port done  out  1  one-cycle pulse at sweep completion.
REQ-015 Port spike_vec  out  N_NEUR  per-neuron spike flags of the last completed sweep.
REQ-016 Port v_mon  out  8  v[mon_sel][W-1:W-8] of committed state.
REQ-017 Port spike_cnt  out  16  total spikes since reset, saturating at 0xFFFF.
REQ-018 Port overrun  out  1  sticky flag: step received while busy.

Function
REQ-019 Per neuron: state v,u (W bits), live mode and current registers, shadow copies latched at sweep start.
REQ-020 Idle + step + ena: copy live mode/current to shadows, busy=1, index=0, next cycle begins updates.
REQ-021 One neuron updated per enabled cycle in index order 0..N_NEUR-1; sweep latency N_NEUR cycles from step to done.
REQ-022 The cycle after the last neuron updates: busy=0, done=1 for one cycle, spike_vec loaded with the sweep's flags.
REQ-023 step while busy is ignored and sets overrun; cleared only by reset.
REQ-024 cfg_wr writes the live register any time; addresses >= N_NEUR ignored; write takes effect at the next sweep start.
REQ-025 ena low mid-sweep stalls index and all state; sweep resumes when ena returns.
REQ-026 Spike: if v > P (0.3, i.e. round(0.3*2^F)), v <= C(mode), u <= u + D(mode), flag set.
REQ-027 Else v <= v + ((v*v>>F) + v + (v>>>2) + (K>>>2) - (u>>>2) + (I>>>2))>>>2, K = round(1.4*2^F).
REQ-028 Else u <= u + ((((v>>>B)-u)>>>A)>>>4), A/B are right-shift amounts from the mode.
REQ-029 I = sign-extended shadow current shifted left by F-6 (integer current /64).
REQ-030 Product v*v full 2W bits; result and every sum computed at W+4 bits, then saturated to W-bit range (no wrap).
REQ-031 Modes (A,B,C,D): 0 RS (2,2,-0.065,0.08); 1 IB (2,2,-0.055,0.04); 2 CH (2,2,-0.050,0.02); 3 FS (1,2,-0.065,0.02); 4 TC (2,3,-0.065,0.05); 5 RZ (1,3,-0.065,0.02); 6 LTS (2,3,-0.065,0.02); 7 = mode 0.
REQ-032 C, D encoded as round(value*2^F) in W bits.
REQ-033 spike_cnt increments by one per spiking neuron update, saturating.
REQ-034 mon_sel >= N_NEUR drives v_mon = 0.

Reset
REQ-035 rst_n low at a clock edge: all v = round(-0.7*2^F), all u = round(-0.2*2^F), modes 0, currents 0, shadows 0.
REQ-036 Reset outputs: busy=0, done=0, spike_vec=0, spike_cnt=0, overrun=0, v_mon = reset v top byte (0xD3 at W=18,F=16).
REQ-037 Reset mid-sweep aborts the sweep; no done pulse is produced.

Verification
REQ-038 Reset, step once, no config -> busy high 4 cycles, done on cycle 5, spike_vec=0, v_mon updates from 0xD3.
REQ-039 Neuron 2 mode 0, current 0x7F, 200 sweeps -> periodic spike_vec[2], v reset to C, spike_cnt equals spike_vec[2] count.
REQ-040 step asserted while busy -> overrun=1, sweep length unchanged, overrun survives later sweeps.
REQ-041 cfg_wr to neuron 1 mid-sweep -> current sweep uses old value, next sweep uses new value (checked against model).
REQ-042 Force v near max with current 0x7F -> v saturates, never wraps negative without a spike.
REQ-043 rst_n low mid-sweep, ena toggled during sweep -> state equals reset values; stalled sweep completes with bit-exact model match.

Source files
------------

// File: rtl/izh_neuron_array.sv
// Time-multiplexed array of Izhikevich neurons in signed fixed point (W bits, F fraction).
// One sweep updates every neuron once, one neuron per enabled clock, in index order.
module izh_neuron_array #(
    parameter int N_NEUR = 4,
    parameter int W      = 18,
    parameter int F      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              step,
    input  logic              cfg_wr,
    input  logic [3:0]        cfg_addr,
    input  logic              cfg_sel,
    input  logic [7:0]        cfg_data,
    input  logic [3:0]        mon_sel,
    output logic              busy,
    output logic              done,
    output logic [N_NEUR-1:0] spike_vec,
    output logic [7:0]        v_mon,
    output logic [15:0]       spike_cnt,
    output logic              overrun
);
    localparam int IW = $clog2(N_NEUR);
    localparam int X  = W + 4;

    // round(milli/1000 * 2^F), rounding half away from zero
    function automatic logic signed [W-1:0] fx(input longint milli);
        longint mag;
        longint r;
        mag = (milli < 0) ? -milli : milli;
        r = (mag * (longint'(1) <<< F) + 500) / 1000;
        if (milli < 0) r = -r;
        return r[W-1:0];
    endfunction

    function automatic logic signed [X-1:0] sx(input logic signed [W-1:0] a);
        return {{4{a[W-1]}}, a};
    endfunction

    localparam logic signed [X-1:0] SAT_HI = {{5{1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [X-1:0] SAT_LO = {{5{1'b1}}, {(W-1){1'b0}}};

    function automatic logic signed [W-1:0] sat(input logic signed [X-1:0] a);
        if (a > SAT_HI) return SAT_HI[W-1:0];
        if (a < SAT_LO) return SAT_LO[W-1:0];
        return a[W-1:0];
    endfunction

    localparam logic signed [W-1:0]   V_RST  = fx(-700);
    localparam logic signed [W-1:0]   U_RST  = fx(-200);
    localparam logic signed [W-1:0]   P_TH   = fx(300);
    localparam logic signed [X-1:0]   K_X    = sx(fx(1400));
    localparam logic signed [W-1:0]   C_RS   = fx(-65);
    localparam logic signed [W-1:0]   C_IB   = fx(-55);
    localparam logic signed [W-1:0]   C_CH   = fx(-50);
    localparam logic signed [W-1:0]   D_RS   = fx(80);
    localparam logic signed [W-1:0]   D_IB   = fx(40);
    localparam logic signed [W-1:0]   D_LO   = fx(20);
    localparam logic signed [W-1:0]   D_TC   = fx(50);
    localparam logic signed [2*W-1:0] SQ_LIM = {{(W-3){1'b0}}, {(X-1){1'b1}}};
    localparam logic [IW-1:0]         IDX_LAST = IW'(N_NEUR - 1);
    localparam logic [4:0]            N_LIM    = 5'(N_NEUR);

    // Handshake: step is a one-cycle request honoured only while idle and ena is high;
    // busy then stays high for N_NEUR enabled cycles, and done pulses for one cycle
    // as busy falls, together with the new spike_vec. A step seen while busy only sets overrun.
    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t state, state_nxt;

    logic [IW-1:0]       idx;
    logic signed [W-1:0] v_r       [N_NEUR];
    logic signed [W-1:0] u_r       [N_NEUR];
    logic [2:0]          mode_live [N_NEUR];
    logic [2:0]          mode_sh   [N_NEUR];
    logic signed [7:0]   cur_live  [N_NEUR];
    logic signed [7:0]   cur_sh    [N_NEUR];
    logic [N_NEUR-1:0]   spike_acc, acc_nxt;
    logic                start, upd, fin, cfg_ok;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        upd       = 1'b0;
        fin       = 1'b0;
        case (state)
            S_IDLE: if (step) begin
                start     = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                upd = 1'b1;
                if (idx == IDX_LAST) begin
                    fin       = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy   = (state == S_RUN);
    assign cfg_ok = ({1'b0, cfg_addr} < N_LIM);

    logic signed [W-1:0]   v_cur, u_cur, c_val, d_val, v_nxt, u_nxt;
    logic [1:0]            sh_a, sh_b;
    logic signed [2*W-1:0] v_wide, vv, sq_full;
    logic signed [X-1:0]   vx, ux, ix, sq, dv_sum, vn_x, un_x;
    logic                  spk;

    always_comb begin
        v_cur = v_r[idx];
        u_cur = u_r[idx];
        sh_a  = 2'd2;
        sh_b  = 2'd2;
        c_val = C_RS;
        d_val = D_RS;
        case (mode_sh[idx])
            3'd1: begin c_val = C_IB; d_val = D_IB; end
            3'd2: begin c_val = C_CH; d_val = D_LO; end
            3'd3: begin sh_a = 2'd1; d_val = D_LO; end
            3'd4: begin sh_b = 2'd3; d_val = D_TC; end
            3'd5: begin sh_a = 2'd1; sh_b = 2'd3; d_val = D_LO; end
            3'd6: begin sh_b = 2'd3; d_val = D_LO; end
            default: ;
        endcase

        vx      = sx(v_cur);
        ux      = sx(u_cur);
        ix      = {{(X-8){cur_sh[idx][7]}}, cur_sh[idx]} <<< (F - 6);
        v_wide  = {{W{v_cur[W-1]}}, v_cur};
        vv      = v_wide * v_wide;
        sq_full = vv >>> F;
        sq      = (sq_full > SQ_LIM) ? SQ_LIM[X-1:0] : sq_full[X-1:0];
        dv_sum  = sq + vx + (vx >>> 2) + (K_X >>> 2) - (ux >>> 2) + (ix >>> 2);
        vn_x    = vx + (dv_sum >>> 2);
        un_x    = ux + ((((vx >>> sh_b) - ux) >>> sh_a) >>> 4);

        spk = (v_cur > P_TH);
        if (spk) begin
            v_nxt = c_val;
            u_nxt = sat(ux + sx(d_val));
        end else begin
            v_nxt = sat(vn_x);
            u_nxt = sat(un_x);
        end
        acc_nxt      = spike_acc;
        acc_nxt[idx] = spk;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            done      <= 1'b0;
            spike_vec <= '0;
            spike_acc <= '0;
            spike_cnt <= '0;
            overrun   <= 1'b0;
            for (int n = 0; n < N_NEUR; n++) begin
                v_r[n]       <= V_RST;
                u_r[n]       <= U_RST;
                mode_live[n] <= '0;
                mode_sh[n]   <= '0;
                cur_live[n]  <= '0;
                cur_sh[n]    <= '0;
            end
        end else if (ena) begin
            state <= state_nxt;
            done  <= fin;
            if (busy && step) overrun <= 1'b1;
            if (start) begin
                idx       <= '0;
                spike_acc <= '0;
                for (int n = 0; n < N_NEUR; n++) begin
                    mode_sh[n] <= mode_live[n];
                    cur_sh[n]  <= cur_live[n];
                end
            end
            if (upd) begin
                v_r[idx]  <= v_nxt;
                u_r[idx]  <= u_nxt;
                spike_acc <= acc_nxt;
                idx       <= fin ? '0 : idx + IW'(1);
                if (spk && spike_cnt != 16'hFFFF) spike_cnt <= spike_cnt + 16'd1;
            end
            if (fin) spike_vec <= acc_nxt;
            // live registers only; they reach the datapath at the next sweep start
            if (cfg_wr && cfg_ok) begin
                if (cfg_sel) cur_live[cfg_addr[IW-1:0]]  <= cfg_data;
                else         mode_live[cfg_addr[IW-1:0]] <= cfg_data[2:0];
            end
        end
    end

    always_comb begin
        v_mon = '0;
        if ({1'b0, mon_sel} < N_LIM) v_mon = v_r[mon_sel[IW-1:0]][W-1:W-8];
    end

endmodule

// File: tb/tb_izh_neuron_array.sv
// Directed bench for izh_neuron_array: hand-computed constants plus a cycle model of
// the neuron equations at the default parameters (N=4, W=18, F=16).
module tb_izh_neuron_array;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n, ena, step, cfg_wr, cfg_sel;
    logic [3:0] cfg_addr, mon_sel;
    logic [7:0] cfg_data;
    logic       busy, done, overrun;
    logic [N-1:0] spike_vec;
    logic [7:0]   v_mon;
    logic [15:0]  spike_cnt;

    izh_neuron_array #(.N_NEUR(N), .W(18), .F(16)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .step(step),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .mon_sel(mon_sel), .busy(busy), .done(done), .spike_vec(spike_vec),
        .v_mon(v_mon), .spike_cnt(spike_cnt), .overrun(overrun)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model state
    longint mv[N], mu[N];
    int     m_mode[N], m_mode_sh[N], m_cur[N], m_cur_sh[N];
    bit     m_busy, m_done, m_ovr;
    int     midx, m_cnt, spikes_n2;
    logic [N-1:0] m_acc, m_svec;

    function automatic longint sat18(input longint a);
        if (a > 131071) return 131071;
        if (a < -131072) return -131072;
        return a;
    endfunction

    function automatic logic [7:0] top8(input longint v);
        longint t;
        t = v >>> 10;
        return t[7:0];
    endfunction

    task automatic model_reset();
        for (int n = 0; n < N; n++) begin
            mv[n] = -45875; mu[n] = -13107;
            m_mode[n] = 0; m_mode_sh[n] = 0; m_cur[n] = 0; m_cur_sh[n] = 0;
        end
        m_busy = 0; m_done = 0; m_ovr = 0; midx = 0; m_cnt = 0;
        m_acc = '0; m_svec = '0;
    endtask

    task automatic model_update(input int n, output bit spk);
        int a, b;
        longint c, d, v, u, sq, sum;
        case (m_mode_sh[n])
            1: begin a = 2; b = 2; c = -3604; d = 2621; end
            2: begin a = 2; b = 2; c = -3277; d = 1311; end
            3: begin a = 1; b = 2; c = -4260; d = 1311; end
            4: begin a = 2; b = 3; c = -4260; d = 3277; end
            5: begin a = 1; b = 3; c = -4260; d = 1311; end
            6: begin a = 2; b = 3; c = -4260; d = 1311; end
            default: begin a = 2; b = 2; c = -4260; d = 5243; end
        endcase
        v = mv[n];
        u = mu[n];
        if (v > 19661) begin
            mv[n] = c;
            mu[n] = sat18(u + d);
            spk = 1;
        end else begin
            sq  = (v * v) >>> 16;
            sum = sq + v + (v >>> 2) + (longint'(91750) >>> 2) - (u >>> 2)
                  + ((longint'(m_cur_sh[n]) * 1024) >>> 2);
            mv[n] = sat18(v + (sum >>> 2));
            mu[n] = sat18(u + ((((v >>> b) - u) >>> a) >>> 4));
            spk = 0;
        end
    endtask

    // advance the model by one clock using the inputs currently driven
    task automatic model_cycle();
        bit spk;
        if (!rst_n) begin
            model_reset();
        end else if (ena) begin
            if (m_busy) begin
                model_update(midx, spk);
                m_acc[midx] = spk;
                if (spk) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (midx == 2) spikes_n2++;
                end
                if (step) m_ovr = 1;
                if (midx == N - 1) begin
                    m_busy = 0; m_done = 1; m_svec = m_acc;
                end else begin
                    midx++; m_done = 0;
                end
            end else begin
                m_done = 0;
                if (step) begin
                    for (int n = 0; n < N; n++) begin
                        m_mode_sh[n] = m_mode[n]; m_cur_sh[n] = m_cur[n];
                    end
                    m_busy = 1; midx = 0; m_acc = '0;
                end
            end
            if (cfg_wr && int'(cfg_addr) < N) begin
                if (cfg_sel) m_cur[cfg_addr] = int'($signed(cfg_data));
                else         m_mode[cfg_addr] = int'(cfg_data[2:0]);
            end
        end
    endtask

    task automatic cyc();
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_step();
        step = 1'b1;
        cyc();
        step = 1'b0;
    endtask

    task automatic cfg(input int addr, input bit sel, input logic [7:0] data);
        cfg_wr = 1'b1; cfg_addr = 4'(addr); cfg_sel = sel; cfg_data = data;
        cyc();
        cfg_wr = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            cyc();
            n++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic check_vmon(input string tag);
        for (int n = 0; n < N; n++) begin
            mon_sel = 4'(n);
            #1;
            check($sformatf("%s_vmon%0d", tag, n), 32'(v_mon), 32'(top8(mv[n])));
        end
        mon_sel = 4'd12;
        #1;
        check({tag, "_vmon_oor"}, 32'(v_mon), 32'd0);
        mon_sel = 4'd0;
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'(m_busy));
        check({tag, "_done"}, 32'(done), 32'(m_done));
        check({tag, "_svec"}, 32'(spike_vec), 32'(m_svec));
        check({tag, "_cnt"}, 32'(spike_cnt), 32'(m_cnt));
        check({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
        check_vmon(tag);
    endtask

    task automatic sweep();
        int n;
        do_step();
        wait_done(20, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n, done_at, done_n, n, dut_n2;
        rst_n = 1'b0; ena = 1'b1; step = 1'b0; cfg_wr = 1'b0;
        cfg_addr = '0; cfg_sel = 1'b0; cfg_data = '0; mon_sel = '0;
        spikes_n2 = 0;
        model_reset();
        cyc(); cyc();
        rst_n = 1'b1;

        // reset state
        check("rst_vmon_hand", 32'(v_mon), 32'hD3);
        check("rst_busy_hand", 32'(busy), 32'd0);
        check_all("rst");

        // first sweep: busy 4 cycles, done on the 5th, one cycle wide
        do_step();
        busy_n = 0; done_at = 0; done_n = 0;
        for (int c = 1; c <= 8; c++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at == 0) done_at = c;
                check_all("sweep1");
            end
            cyc();
        end
        check("busy_cycles", 32'(busy_n), 32'd4);
        check("done_cycle", 32'(done_at), 32'd5);
        check("done_width", 32'(done_n), 32'd1);
        check("sweep1_vmon0_hand", 32'(v_mon), 32'hD3);

        // ena low mid-sweep stalls; step while stalled is ignored
        do_step();
        cyc(); cyc();
        ena = 1'b0; step = 1'b1;
        cyc(); cyc(); cyc();
        check_all("stall");
        step = 1'b0; ena = 1'b1;
        wait_done(10, n);
        check("stall_resume_cycles", 32'(n), 32'd2);
        check_all("stall_done");

        // config write mid-sweep applies from the next sweep only
        do_step();
        cfg_wr = 1'b1; cfg_addr = 4'd1; cfg_sel = 1'b1; cfg_data = 8'h50;
        cyc();
        cfg_wr = 1'b0;
        cfg(12, 0, 8'h07);
        wait_done(10, n);
        check_all("cfg_old");
        sweep();
        check_all("cfg_new");

        // step while busy: overrun sticky, sweep length unchanged
        do_step();
        step = 1'b1;
        cyc();
        step = 1'b0;
        wait_done(10, n);
        check("ovr_len", 32'(1 + n), 32'd4);
        check_all("ovr");
        sweep();
        check("ovr_sticky", 32'(overrun), 32'd1);

        // neuron 2 regular spiking on a strong current
        cfg(1, 1, 8'h00);
        cfg(2, 0, 8'h00);
        cfg(2, 1, 8'h7F);
        spikes_n2 = 0; dut_n2 = 0;
        for (int s = 0; s < 200; s++) begin
            sweep();
            check("rs_svec", 32'(spike_vec), 32'(m_svec));
            check("rs_cnt", 32'(spike_cnt), 32'(m_cnt));
            mon_sel = 4'd2;
            #1;
            check("rs_vmon2", 32'(v_mon), 32'(top8(mv[2])));
            if (spike_vec[2]) begin
                dut_n2++;
                check("rs_v_to_c", 32'(v_mon), 32'hFB);
            end
            mon_sel = 4'd0;
        end
        check("rs_n2_count", 32'(dut_n2), 32'(spikes_n2));
        check("rs_periodic", 32'(dut_n2 > 3), 32'd1);
        check_all("rs_end");

        // stress: strong positive and negative currents, other modes
        cfg(0, 1, 8'h80);
        cfg(0, 0, 8'h05);
        cfg(3, 0, 8'h03);
        cfg(3, 1, 8'h7F);
        cfg(1, 0, 8'h06);
        cfg(1, 1, 8'h7F);
        for (int s = 0; s < 30; s++) begin
            sweep();
            check_all("stress");
        end

        // reset mid-sweep aborts without a done pulse
        do_step();
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check_all("midrst");
        check("midrst_vmon_hand", 32'(v_mon), 32'hD3);
        done_n = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) done_n++;
            cyc();
        end
        check("midrst_no_done", 32'(done_n), 32'd0);

        // stalled sweep after reset still matches the model
        cfg(2, 1, 8'h40);
        sweep();
        do_step();
        cyc();
        ena = 1'b0;
        cyc(); cyc();
        ena = 1'b1;
        wait_done(10, n);
        check_all("final");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
